// File: rtl/dmem_responder.sv
// dmem_responder
//   Word-addressed 32-bit data memory for the MIPS load/store port. It sits
//   behind a valid/ready request channel and a valid/ready response channel.
//   It takes WAIT_STATES extra cycles between accepting a request and
//   performing the access. Only one transaction is in flight at a time.
//
// Parameters
//   ADDR_W       word-address width; depth is 2**ADDR_W words
//   WAIT_STATES  cycles from accept to commit (0..15)
//
// Ports
//   CLK        clock, rising edge
//   RST        synchronous active-high reset
//   REQ_VALID  request present           REQ_READY  responder can accept
//   REQ_WE     1 = store, 0 = load       REQ_ADDR   word index
//   REQ_WDATA  store data                REQ_BE     byte enables (optional)
//   RSP_VALID  response present          RSP_READY  initiator takes response
//   RSP_RDATA  load data, or the word left in memory by a store
//
// Build option
//   DMEM_BYTE_STROBE_EN  adds REQ_BE[3:0]. A store writes only the enabled
//                        byte lanes. Without it, every store writes all four
//                        lanes.
module dmem_responder #(
  parameter int ADDR_W      = 7,
  parameter int WAIT_STATES = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WE,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [31:0]       REQ_WDATA,
`ifdef DMEM_BYTE_STROBE_EN
  input  logic [3:0]        REQ_BE,
`endif
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [31:0]       RSP_RDATA
);

  localparam int         DEPTH     = 1 << ADDR_W;
  localparam bit         ZERO_WAIT = (WAIT_STATES == 0);
  localparam logic [3:0] CNT_INIT  = ZERO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t              state_reg, state_next;
  logic [3:0]          cnt_reg, cnt_next;
  logic                we_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [31:0]         wdata_reg;
  logic [3:0]          be_reg;
  logic [31:0]         rdata_reg;
  logic [31:0]         mem [DEPTH];

  logic                accept;
  logic                commit;
  logic                use_live;
  logic                commit_we;
  logic [ADDR_W-1:0]   commit_addr;
  logic [31:0]         commit_wdata;
  logic [3:0]          commit_be;
  logic [3:0]          req_be;
  logic [3:0]          lane_we;

`ifdef DMEM_BYTE_STROBE_EN
  assign req_be = REQ_BE;
`else
  assign req_be = 4'hF;
`endif

  assign REQ_READY = (state_reg == IDLE) && !RST;
  assign RSP_VALID = (state_reg == RESP);
  assign RSP_RDATA = rdata_reg;
  assign accept    = REQ_VALID && REQ_READY;

  // With zero wait states the access commits on the accepting edge. In that
  // case it uses the live request fields, because the latched copies are not
  // loaded until that same edge.
  assign use_live     = (state_reg == IDLE);
  assign commit_we    = use_live ? REQ_WE    : we_reg;
  assign commit_addr  = use_live ? REQ_ADDR  : addr_reg;
  assign commit_wdata = use_live ? REQ_WDATA : wdata_reg;
  assign commit_be    = use_live ? req_be    : be_reg;

  // Reset blocks the commit, so a store still in flight is discarded.
  assign commit = !RST &&
                  ((ZERO_WAIT && accept) ||
                   (state_reg == BUSY && cnt_reg == 4'd0));

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_we[gi] = commit_we & commit_be[gi];
    end
  endgenerate

  // Request capture. The fields are sampled only on the accepting edge, so
  // later changes on the request bus have no effect.
  always_ff @(posedge CLK) begin
    if (accept) begin
      we_reg    <= REQ_WE;
      addr_reg  <= REQ_ADDR;
      wdata_reg <= REQ_WDATA;
      be_reg    <= req_be;
    end
  end

  // Memory array. It is not reset.
  always_ff @(posedge CLK) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_we[i]) begin
          mem[commit_addr][8*i +: 8] <= commit_wdata[8*i +: 8];
        end
      end
    end
  end

  // Registered read port. On a store, each lane returns the value it holds
  // after the write: the new byte where it is enabled, otherwise the old byte.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rdata_reg <= '0;
    end else if (commit) begin
      for (int i = 0; i < 4; i++) begin
        rdata_reg[8*i +: 8] <= lane_we[i] ? commit_wdata[8*i +: 8]
                                          : mem[commit_addr][8*i +: 8];
      end
    end else if (state_reg == RESP && RSP_READY) begin
      rdata_reg <= '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (ZERO_WAIT) begin
            state_next = RESP;
          end else begin
            state_next = BUSY;
            cnt_next   = CNT_INIT;
          end
        end
      end
      BUSY: begin
        if (cnt_reg == 4'd0) begin
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP: begin
        if (RSP_READY) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed testbench for dmem_responder.
// dut  : WAIT_STATES = 2
// zdut : WAIT_STATES = 0, with RSP_READY tied high during its test
// The byte-strobe scenario runs when DMEM_BYTE_STROBE_EN is defined.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [6:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;

  logic        z_req_valid = 1'b0;
  logic        z_req_ready;
  logic        z_req_we = 1'b0;
  logic [6:0]  z_req_addr = '0;
  logic [31:0] z_req_wdata = '0;
  logic        z_rsp_valid;
  logic        z_rsp_ready = 1'b0;
  logic [31:0] z_rsp_rdata;

`ifdef DMEM_BYTE_STROBE_EN
  logic [3:0]  req_be = 4'hF;
  logic [3:0]  z_req_be = 4'hF;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(7), .WAIT_STATES(2)) dut (
    .CLK       (clk),
    .RST       (rst),
    .REQ_VALID (req_valid),
    .REQ_READY (req_ready),
    .REQ_WE    (req_we),
    .REQ_ADDR  (req_addr),
    .REQ_WDATA (req_wdata),
`ifdef DMEM_BYTE_STROBE_EN
    .REQ_BE    (req_be),
`endif
    .RSP_VALID (rsp_valid),
    .RSP_READY (rsp_ready),
    .RSP_RDATA (rsp_rdata)
  );

  dmem_responder #(.ADDR_W(7), .WAIT_STATES(0)) zdut (
    .CLK       (clk),
    .RST       (rst),
    .REQ_VALID (z_req_valid),
    .REQ_READY (z_req_ready),
    .REQ_WE    (z_req_we),
    .REQ_ADDR  (z_req_addr),
    .REQ_WDATA (z_req_wdata),
`ifdef DMEM_BYTE_STROBE_EN
    .REQ_BE    (z_req_be),
`endif
    .RSP_VALID (z_rsp_valid),
    .RSP_READY (z_rsp_ready),
    .RSP_RDATA (z_rsp_rdata)
  );

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request, wait (bounded) until it is accepted, then scramble the
  // request bus. wait_cyc returns -1 if the request was never accepted.
  task automatic send_req(input logic we, input logic [6:0] addr,
                          input logic [31:0] wd, output int wait_cyc);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    wait_cyc  = 0;
    while (!req_ready && wait_cyc < 50) begin
      step();
      wait_cyc++;
    end
    if (!req_ready) wait_cyc = -1;
    step();
    req_valid = 1'b0;
    req_we    = ~we;
    req_addr  = ~addr;
    req_wdata = ~wd;
  endtask

  // Count the edges from the accept until RSP_VALID appears. Returns -1 on
  // timeout.
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      step();
      lat++;
    end
    if (!rsp_valid) lat = -1;
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    n_checks++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_rdata got=%h exp=00000000", rsp_rdata); end
    rst = 1'b0;
    step();
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL idle_req_ready got=%b exp=1", req_ready); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL idle_rsp_valid got=%b exp=0", rsp_valid); end
    n_checks++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL idle_rsp_rdata got=%h exp=00000000", rsp_rdata); end
    n_checks++; if (z_req_ready !== 1'b1) begin n_fail++; $display("FAIL z_idle_req_ready got=%b exp=1", z_req_ready); end
    $display("reset released: req_ready=%b rsp_valid=%b rsp_rdata=%h", req_ready, rsp_valid, rsp_rdata);
  endtask

  task automatic test_store_load();
    logic        we_t [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [6:0]  ad_t [8] = '{7'h05, 7'h05, 7'h7F, 7'h00, 7'h10, 7'h7F, 7'h00, 7'h10};
    logic [31:0] wd_t [8] = '{32'hDEADBEEF, 32'h0, 32'h0BADF00D, 32'hCAFEF00D,
                              32'h0, 32'h0, 32'h0, 32'h0};
    logic [31:0] ex_t [8] = '{32'hDEADBEEF, 32'hDEADBEEF, 32'h0BADF00D, 32'hCAFEF00D,
                              32'h0, 32'h0BADF00D, 32'hCAFEF00D, 32'h0};
    int w, lat;
    for (int k = 0; k < 8; k++) begin
      send_req(we_t[k], ad_t[k], wd_t[k], w);
      n_checks++; if (w !== 0) begin n_fail++; $display("FAIL sl_accept[%0d] wait=%0d exp=0", k, w); end
      wait_rsp(lat);
      n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL sl_latency[%0d] got=%0d exp=2", k, lat); end
      n_checks++; if (rsp_rdata !== ex_t[k]) begin n_fail++; $display("FAIL sl_rdata[%0d] got=%h exp=%h", k, rsp_rdata, ex_t[k]); end
      $display("%s addr=%h wdata=%h rdata=%h lat=%0d", we_t[k] ? "store" : "load ", ad_t[k], wd_t[k], rsp_rdata, lat);
      release_rsp();
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL sl_rsp_drop[%0d] got=%b exp=0", k, rsp_valid); end
      n_checks++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL sl_rdata_clear[%0d] got=%h exp=00000000", k, rsp_rdata); end
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL sl_ready_back[%0d] got=%b exp=1", k, req_ready); end
    end
  endtask

  task automatic test_backpressure();
    int w, lat;
    send_req(1'b0, 7'h05, 32'h0, w);
    wait_rsp(lat);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL bp_latency got=%0d exp=2", lat); end
    // Competing store held on the bus while the response is stalled.
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 7'h05;
    req_wdata = 32'h55555555;
    for (int c = 0; c < 5; c++) begin
      step();
      n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_hold[%0d] got=%b exp=1", c, rsp_valid); end
      n_checks++; if (rsp_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bp_rdata_hold[%0d] got=%h exp=deadbeef", c, rsp_rdata); end
      n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_req_ready[%0d] got=%b exp=0", c, req_ready); end
    end
    $display("load  addr=05 rdata=%h held 5 cycles", rsp_rdata);
    release_rsp();
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid got=%b exp=0", rsp_valid); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_not_yet_accepted got=%b exp=1", req_ready); end
    step();
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_accepted_busy got=%b exp=0", req_ready); end
    req_valid = 1'b0;
    req_wdata = 32'h0;
    req_addr  = 7'h7F;
    wait_rsp(lat);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL bp_store_latency got=%0d exp=2", lat); end
    n_checks++; if (rsp_rdata !== 32'h55555555) begin n_fail++; $display("FAIL bp_store_rdata got=%h exp=55555555", rsp_rdata); end
    $display("store addr=05 wdata=55555555 rdata=%h lat=%0d", rsp_rdata, lat);
    release_rsp();
    send_req(1'b0, 7'h05, 32'h0, w);
    wait_rsp(lat);
    n_checks++; if (rsp_rdata !== 32'h55555555) begin n_fail++; $display("FAIL bp_reload got=%h exp=55555555", rsp_rdata); end
    $display("load  addr=05 rdata=%h lat=%0d", rsp_rdata, lat);
    release_rsp();
  endtask

  task automatic test_reset_mid();
    int w, lat;
    send_req(1'b1, 7'h10, 32'h12345678, w);
    // Hold reset across the edge on which the commit would have happened.
    rst = 1'b1;
    step();
    step();
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rm_rsp_valid got=%b exp=0", rsp_valid); end
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rm_ready_in_reset got=%b exp=0", req_ready); end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rm_no_rsp[%0d] got=%b exp=0", c, rsp_valid); end
    end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rm_ready_after got=%b exp=1", req_ready); end
    $display("store addr=10 wdata=12345678 discarded by reset");
    send_req(1'b0, 7'h10, 32'h0, w);
    wait_rsp(lat);
    n_checks++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL rm_old_contents got=%h exp=00000000", rsp_rdata); end
    $display("load  addr=10 rdata=%h lat=%0d", rsp_rdata, lat);
    // A reset that arrives in RESP drops the response.
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rr_rsp_dropped got=%b exp=0", rsp_valid); end
    n_checks++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL rr_rdata_cleared got=%h exp=00000000", rsp_rdata); end
    step();
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rr_ready_after got=%b exp=1", req_ready); end
    $display("load  addr=10 response dropped by reset");
  endtask

  task automatic test_zero_wait();
    logic        we_t [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [6:0]  ad_t [6] = '{7'h01, 7'h7F, 7'h01, 7'h7F, 7'h01, 7'h01};
    logic [31:0] wd_t [6] = '{32'h01020304, 32'hFFFFFFFF, 32'h0, 32'h0, 32'hA5A5A5A5, 32'h0};
    logic [31:0] ex_t [6] = '{32'h01020304, 32'hFFFFFFFF, 32'h01020304, 32'hFFFFFFFF,
                              32'hA5A5A5A5, 32'hA5A5A5A5};
    z_rsp_ready = 1'b1;
    z_req_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      n_checks++; if (z_req_ready !== 1'b1) begin n_fail++; $display("FAIL zw_ready[%0d] got=%b exp=1", k, z_req_ready); end
      z_req_we    = we_t[k];
      z_req_addr  = ad_t[k];
      z_req_wdata = wd_t[k];
      step();
      n_checks++; if (z_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL zw_valid[%0d] got=%b exp=1", k, z_rsp_valid); end
      n_checks++; if (z_rsp_rdata !== ex_t[k]) begin n_fail++; $display("FAIL zw_rdata[%0d] got=%h exp=%h", k, z_rsp_rdata, ex_t[k]); end
      n_checks++; if (z_req_ready !== 1'b0) begin n_fail++; $display("FAIL zw_busy[%0d] got=%b exp=0", k, z_req_ready); end
      $display("zw %s addr=%h wdata=%h rdata=%h", we_t[k] ? "store" : "load ", ad_t[k], wd_t[k], z_rsp_rdata);
      z_req_wdata = ~wd_t[k];
      step();
      n_checks++; if (z_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL zw_gap[%0d] got=%b exp=0", k, z_rsp_valid); end
    end
    z_req_valid = 1'b0;
    z_rsp_ready = 1'b0;
  endtask

`ifdef DMEM_BYTE_STROBE_EN
  task automatic test_byte_strobe();
    logic        we_t [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] wd_t [5] = '{32'h11223344, 32'hAABBCCDD, 32'h0, 32'hFFFFFFFF, 32'h0};
    logic [3:0]  be_t [5] = '{4'hF, 4'b0101, 4'b0000, 4'b0000, 4'b1010};
    logic [31:0] ex_t [5] = '{32'h11223344, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD};
    int w, lat;
    for (int k = 0; k < 5; k++) begin
      req_be = be_t[k];
      send_req(we_t[k], 7'h03, wd_t[k], w);
      req_be = ~be_t[k];
      wait_rsp(lat);
      n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL be_latency[%0d] got=%0d exp=2", k, lat); end
      n_checks++; if (rsp_rdata !== ex_t[k]) begin n_fail++; $display("FAIL be_rdata[%0d] got=%h exp=%h", k, rsp_rdata, ex_t[k]); end
      $display("be %s addr=03 be=%b wdata=%h rdata=%h", we_t[k] ? "store" : "load ", be_t[k], wd_t[k], rsp_rdata);
      release_rsp();
    end
    req_be = 4'hF;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_store_load();
    test_backpressure();
    test_reset_mid();
    test_zero_wait();
`ifdef DMEM_BYTE_STROBE_EN
    test_byte_strobe();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
